// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_seq_pkg;

   localparam int DEF_OP_WIDTH   = 8;
   localparam int DEF_ACC_WIDTH  = 32;
   localparam int DEF_LEN_WIDTH  = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      SETTLE,
      OUTPUT
   } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// Depth must be a power of two so the pointers wrap on their own.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0] LEVEL_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   level;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LEVEL);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset discards everything queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      level <= level + LEVEL_ONE;
         else if (!do_push && do_pop) level <= level - LEVEL_ONE;
      end
   end

   // Storage array needs no reset; only entries behind the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Streams buffered operand pairs into an external Mac for a programmable-length
// dot product, then hands the accumulator value downstream over valid/ready.
module mac_dot_sequencer
   import mac_seq_pkg::*;
#(
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_WIDTH-1:0]  in_a,
   input  logic [OP_WIDTH-1:0]  in_b,
   output logic                 mac_clear,
   output logic                 mac_hold,
   output logic [OP_WIDTH-1:0]  mac_a,
   output logic [OP_WIDTH-1:0]  mac_b,
   input  logic [ACC_WIDTH-1:0] mac_c,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_WIDTH-1:0] res_data
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

   seq_state_t state;
   seq_state_t next_state;

   logic [LEN_WIDTH-1:0]    len;
   logic [LEN_WIDTH-1:0]    count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    last_pop;
   logic [2*OP_WIDTH-1:0]   fifo_head;

   assign in_ready = ~fifo_full;
   assign pop      = (state == FEED) && !fifo_empty;
   assign last_pop = pop && (count == len - LEN_ONE);

   sync_fifo #(
      .WIDTH (2*OP_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid & ~fifo_full),
      .pop       (pop),
      .push_data ({in_a, in_b}),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic: a zero-length run skips FEED entirely.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = CLEAR;
         CLEAR:   next_state = (len == '0) ? SETTLE : FEED;
         FEED:    if (last_pop) next_state = SETTLE;
         SETTLE:  next_state = OUTPUT;
         OUTPUT:  if (res_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Mac controls: operands only reach the Mac on a popping FEED cycle, zero otherwise.
   always_comb begin
      busy      = (state != IDLE);
      res_valid = (state == OUTPUT);
      mac_clear = (state == CLEAR);
      mac_hold  = 1'b1;
      mac_a     = '0;
      mac_b     = '0;
      if (pop) begin
         mac_hold = 1'b0;
         mac_a    = fifo_head[2*OP_WIDTH-1:OP_WIDTH];
         mac_b    = fifo_head[OP_WIDTH-1:0];
      end
   end

   // Run length, pop counter and the captured result.
   always_ff @(posedge clk) begin
      if (reset) begin
         len      <= '0;
         count    <= '0;
         res_data <= '0;
      end else begin
         if (state == IDLE && start) begin
            len   <= cfg_len;
            count <= '0;
         end
         if (pop)             count    <= count + LEN_ONE;
         if (state == SETTLE) res_data <= mac_c;
      end
   end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural Mac attached; results are
// predicted from a queue of accepted operand pairs summed with plain arithmetic.
module tb_mac_dot_sequencer;

   localparam int OP_W  = 8;
   localparam int ACC_W = 16;
   localparam int LEN_W = 8;
   localparam int DEPTH = 4;

   logic              clk;
   logic              reset;
   logic              start;
   logic [LEN_W-1:0]  cfg_len;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              mac_clear;
   logic              mac_hold;
   logic [OP_W-1:0]   mac_a;
   logic [OP_W-1:0]   mac_b;
   logic [ACC_W-1:0]  mac_c;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;

   logic [ACC_W-1:0]    mac_acc;
   logic [2*OP_W-1:0]   model_q[$];
   logic [2*OP_W-1:0]   feed_q[$];
   int                  checks = 0;
   int                  errors = 0;
   int                  clear_cnt = 0;
   int                  pop_cnt = 0;

   mac_dot_sequencer #(
      .OP_WIDTH   (OP_W),
      .ACC_WIDTH  (ACC_W),
      .LEN_WIDTH  (LEN_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mac_clear (mac_clear),
      .mac_hold  (mac_hold),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_c     (mac_c),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Attached Mac: shares reset, clears on mac_clear, accumulates when not held.
   always @(posedge clk) begin
      if (reset || mac_clear) mac_acc <= '0;
      else if (!mac_hold)     mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
   end
   assign mac_c = mac_acc;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Watches the Mac interface: operands must appear in arrival order, and be zero when held.
   always @(negedge clk) begin
      if (mac_clear === 1'b1) clear_cnt++;
      if (mac_hold === 1'b0) begin
         pop_cnt++;
         checkOutput("pop_has_data", 64'(feed_q.size() > 0), 64'd1);
         if (feed_q.size() > 0) begin
            checkOutput("mac_operands", 64'({mac_a, mac_b}), 64'(feed_q[0]));
            void'(feed_q.pop_front());
         end
      end else begin
         checkOutput("hold_zero_ops", 64'({mac_hold, mac_a, mac_b}), 64'({1'b1, 16'd0}));
      end
   end

   // Offers one operand pair; called at a negedge, returns at a later negedge.
   task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("push_accepted", 64'(in_ready), 64'd1);
      if (in_ready) begin
         model_q.push_back({a, b});
         feed_q.push_back({a, b});
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // One complete dot product: start, wait for the result, optional backpressure, handshake.
   task automatic runDot(input int len, input bit chk_lat, input int bp, input bit poke_start);
      int                cyc;
      int                base_clr;
      int                base_pop;
      longint unsigned   sum;
      logic [ACC_W-1:0]  exp;
      logic [2*OP_W-1:0] pair;
      base_clr = clear_cnt;
      base_pop = pop_cnt;
      checkOutput("idle_before_start", 64'(busy), 64'd0);
      start   = 1'b1;
      cfg_len = LEN_W'(len);
      cyc     = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end while (!res_valid && cyc < 400);
      checkOutput("res_valid_seen", 64'(res_valid), 64'd1);
      if (chk_lat) checkOutput("latency", 64'(cyc), 64'(len + 3));
      sum = 0;
      for (int i = 0; i < len; i++) begin
         if (model_q.size() > 0) begin
            pair = model_q.pop_front();
            sum  = sum + longint'(pair[2*OP_W-1:OP_W]) * longint'(pair[OP_W-1:0]);
         end
      end
      exp = ACC_W'(sum % (64'd1 << ACC_W));
      checkOutput("res_data", 64'(res_data), 64'(exp));
      checkOutput("clear_pulses", 64'(clear_cnt - base_clr), 64'd1);
      checkOutput("pop_count", 64'(pop_cnt - base_pop), 64'(len));
      for (int k = 0; k < bp; k++) begin
         if (poke_start && k == 1) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         checkOutput("bp_res_valid", 64'(res_valid), 64'd1);
         checkOutput("bp_res_data", 64'(res_data), 64'(exp));
         checkOutput("bp_busy", 64'(busy), 64'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("busy_after", 64'(busy), 64'd0);
      checkOutput("res_valid_after", 64'(res_valid), 64'd0);
      @(negedge clk);
      checkOutput("still_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      int len;
      int need;
      int pre;
      int base_pop;
      reset     = 1'b1;
      start     = 1'b0;
      cfg_len   = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_mac_clear", 64'(mac_clear), 64'd0);
      checkOutput("rst_mac_hold", 64'(mac_hold), 64'd1);
      checkOutput("rst_mac_ops", 64'({mac_a, mac_b}), 64'd0);
      checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
      checkOutput("rst_res_data", 64'(res_data), 64'd0);

      $display("[TB] basic");
      applyStimulus(8'd1, 8'd4);
      applyStimulus(8'd2, 8'd5);
      applyStimulus(8'd3, 8'd6);
      runDot(3, 1'b1, 0, 1'b0);

      $display("[TB] bubbles");
      fork
         runDot(3, 1'b0, 0, 1'b0);
         begin
            applyStimulus(8'd1, 8'd4);
            repeat (2) @(negedge clk);
            applyStimulus(8'd2, 8'd5);
            repeat (2) @(negedge clk);
            applyStimulus(8'd3, 8'd6);
         end
      join

      $display("[TB] zero length");
      applyStimulus(8'd9, 8'd9);
      applyStimulus(8'd1, 8'd1);
      runDot(0, 1'b1, 0, 1'b0);
      applyStimulus(8'd2, 8'd2);
      applyStimulus(8'd3, 8'd3);
      checkOutput("kept_entries_full", 64'(in_ready), 64'd0);
      runDot(4, 1'b1, 0, 1'b0);

      $display("[TB] overflow and backpressure");
      applyStimulus(8'd255, 8'd255);
      applyStimulus(8'd255, 8'd255);
      runDot(2, 1'b1, 5, 1'b1);

      $display("[TB] back-to-back");
      repeat (4) applyStimulus(8'd2, 8'd3);
      fork
         runDot(2, 1'b1, 0, 1'b0);
         applyStimulus(8'd2, 8'd3);
      join
      runDot(3, 1'b1, 0, 1'b0);

      $display("[TB] reset mid-feed");
      applyStimulus(8'd5, 8'd6);
      base_pop = pop_cnt;
      start    = 1'b1;
      cfg_len  = 8'd3;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("midfeed_busy", 64'(busy), 64'd1);
      checkOutput("midfeed_pops", 64'(pop_cnt - base_pop), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      checkOutput("abort_res_valid", 64'(res_valid), 64'd0);
      checkOutput("abort_mac_hold", 64'(mac_hold), 64'd1);
      reset = 1'b0;
      model_q.delete();
      feed_q.delete();
      @(negedge clk);
      applyStimulus(8'd7, 8'd7);
      runDot(1, 1'b1, 0, 1'b0);

      $display("[TB] random runs");
      for (int it = 0; it < 25; it++) begin
         pre = $urandom_range(0, DEPTH - model_q.size());
         for (int p = 0; p < pre; p++) applyStimulus(OP_W'($urandom), OP_W'($urandom));
         len  = $urandom_range(0, 8);
         need = (len > model_q.size()) ? len - model_q.size() : 0;
         fork
            runDot(len, need == 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            begin
               for (int p = 0; p < need; p++) begin
                  repeat ($urandom_range(0, 2)) @(negedge clk);
                  applyStimulus(OP_W'($urandom), OP_W'($urandom));
               end
            end
         join
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Control and streaming front end for one Mac instance. It takes operand pairs from an upstream valid/ready stream, buffers them, and drives the MAC's clear/hold/operand inputs for a dot product of programmable length. It then reads back the MAC accumulator and presents the result on a downstream valid/ready interface. It sits between the operand loader and the result collector of the TPU datapath.

Parameters:
OP_WIDTH, 8, operand width; must match the attached Mac.
ACC_WIDTH, 32, accumulator width; must match the attached Mac.
LEN_WIDTH, 8, width of the dot-product length field.
FIFO_DEPTH, 4, input operand FIFO entries; power of two, at least 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a dot product; sampled only in IDLE
cfg_len  in  LEN_WIDTH  number of operand pairs; latched on accepted start
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_a  in  OP_WIDTH  operand A
in_b  in  OP_WIDTH  operand B
mac_clear  out  1  drives Mac reset; clears accumulator next edge
mac_hold  out  1  drives Mac ena; 1 = accumulator holds, 0 = accumulates mac_a*mac_b
mac_a  out  OP_WIDTH  operand to Mac A
mac_b  out  OP_WIDTH  operand to Mac B
mac_c  in  ACC_WIDTH  Mac accumulator output C
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  ACC_WIDTH  captured dot-product result

Behaviour:
- Reset state: IDLE, FIFO empty, count 0, len 0.
- Reset outputs: busy=0, in_ready=1, mac_clear=0, mac_hold=1, mac_a=0, mac_b=0, res_valid=0, res_data=0.
- Reset mid-operation aborts the dot product with no result emitted and discards FIFO contents. The Mac shares the reset.
- FIFO:
  - push = in_valid & in_ready; in_ready = !full in every state, so prefetch is allowed in IDLE.
  - No push when full, even if a pop occurs in the same cycle.
  - Entries beyond cfg_len remain queued for the next dot product.
- FSM states: IDLE, CLEAR, FEED, SETTLE, OUTPUT.
  - IDLE: on start, latch len = cfg_len, count = 0, go to CLEAR. A start asserted in any other state is ignored.
  - CLEAR (1 cycle): mac_clear=1, mac_hold=1. Go to SETTLE if len==0, else FEED.
  - FEED: pop = FIFO non-empty.
    - On pop: mac_hold=0, mac_a/mac_b = FIFO head (combinational), count increments.
    - On empty: mac_hold=1 and mac_a=mac_b=0 (bubble; no accumulate).
    - When a pop occurs with count == len-1, go to SETTLE.
  - SETTLE (1 cycle): mac_hold=1. mac_c now holds the final sum. Register res_data <= mac_c at the end of the cycle, then go to OUTPUT.
  - OUTPUT: res_valid=1 with res_data stable until res_valid & res_ready, then go to IDLE. mac_hold=1 throughout.
- In every state except a popping FEED cycle: mac_hold=1, mac_a=mac_b=0.
- Latency, FIFO pre-filled and no stalls: res_valid rises len+3 cycles after the start sample edge (IDLE→CLEAR→len×FEED→SETTLE→OUTPUT). For len=0 it rises 3 cycles after.
- Arithmetic: products are unsigned. The accumulator wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
- len counts up to 2^LEN_WIDTH-1. count is LEN_WIDTH bits wide and never wraps within a dot product.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, CLEAR, FEED, SETTLE, OUTPUT) and default width constants.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty, first-word-fall-through head.
- The Mac is instantiated by the parent, not inside this block. The bench instantiates mac_dot_sequencer together with a Mac.

Test Plan:
- Basic: OP=8, ACC=32. Push A=(1,2,3), B=(4,5,6), then start with len=3 → res_data=32. res_valid rises exactly 6 cycles after the start edge. mac_clear pulses once.
- Bubbles: start len=3 with an empty FIFO, then feed pairs with in_valid gaps of 2 cycles → res_data=32. mac_hold=1 on every gap cycle.
- Zero length: start with len=0 while the FIFO holds 2 pairs → res_data=0 after 3 cycles. The FIFO still holds 2 entries afterward.
- Overflow and backpressure: ACC=16, push (255,255)×2, start len=2 → res_data=64514. Hold res_ready low for 5 cycles: res_valid and res_data stay stable and busy stays 1. A start pulse asserted during OUTPUT is ignored.
- Back-to-back: push 5 pairs, all (2,3), then start len=2 → result 12. Then start len=3 → result 18. Leftover pairs are consumed in order.
- Reset mid-FEED after 1 of 3 pops → next cycle: IDLE, busy=0, in_ready=1, no res_valid. A subsequent len=1 run with (7,7) → result 49.
